// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard: forward-select codes,
// per-stage in-flight record, bubble constants and small helpers.
package hazard_pkg;

  localparam int HZ_AW = 5;  // register-address width
  localparam int HZ_TW = 2;  // Tuse/Tnew width

  // Forward-source select codes shared by the D- and E-stage muxes
  localparam logic [1:0] FWD_NONE = 2'd0;
  localparam logic [1:0] FWD_E    = 2'd1;
  localparam logic [1:0] FWD_M    = 2'd2;
  localparam logic [1:0] FWD_W    = 2'd3;

  // One in-flight instruction: where it writes, whether it writes, and
  // how many cycles remain until its result exists
  typedef struct packed {
    logic [HZ_AW-1:0] a3;
    logic             we;
    logic [HZ_TW-1:0] tnew;
  } stage_rec_t;

  // The E record also remembers the operands of the instruction in E,
  // so the E-stage forward selects can be produced here
  typedef struct packed {
    stage_rec_t       rec;
    logic [HZ_AW-1:0] rs;
    logic [HZ_AW-1:0] rt;
  } e_rec_t;

  localparam stage_rec_t REC_BUBBLE = '0;
  localparam e_rec_t     E_BUBBLE   = '0;

  // A record only produces a value if it writes a register other than $0
  function automatic logic is_producer(input stage_rec_t r);
    return r.we && (r.a3 != '0);
  endfunction

  // Tnew counts down by one per stage and stops at zero
  function automatic logic [HZ_TW-1:0] tnew_dec(input logic [HZ_TW-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  // Record as it looks one stage further down the pipe
  function automatic stage_rec_t rec_advance(input stage_rec_t r);
    stage_rec_t n;
    n      = r;
    n.tnew = tnew_dec(r.tnew);
    return n;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side view of the hazard scoreboard: D-stage decode fields in,
// stall and forward selects out.
//
// Handshake: there is no valid/ready pair. The decoder presents its fields
// every cycle (a bubble is simply regwrite_d=0 with no operands used), and
// stall is the only back-pressure: while stall=1 the decoder must hold the
// same D-stage fields, and the scoreboard inserts a bubble into E.
interface hazard_scoreboard_if #(
  parameter int AW = 5,
  parameter int TW = 2
);
  logic [AW-1:0] rs_d;
  logic          rs_use_d;
  logic [TW-1:0] tuse_rs_d;
  logic [AW-1:0] rt_d;
  logic          rt_use_d;
  logic [TW-1:0] tuse_rt_d;
  logic [AW-1:0] a3_d;
  logic          regwrite_d;
  logic [TW-1:0] tnew_d;
  logic          stall;
  logic [1:0]    fwd_rs_d;
  logic [1:0]    fwd_rt_d;
  logic [1:0]    fwd_rs_e;
  logic [1:0]    fwd_rt_e;

  // Decoder / pipeline control side
  modport master (
    output rs_d, rs_use_d, tuse_rs_d, rt_d, rt_use_d, tuse_rt_d,
    output a3_d, regwrite_d, tnew_d,
    input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e
  );

  // Scoreboard side
  modport slave (
    input  rs_d, rs_use_d, tuse_rs_d, rt_d, rt_use_d, tuse_rt_d,
    input  a3_d, regwrite_d, tnew_d,
    output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e
  );
endinterface

// File: rtl/hazard_match.sv
// Youngest-producer lookup for one operand address across the E, M and W
// records. The E record can be masked so the same block serves the
// E-stage operands, which only look at older stages.
module hazard_match
  import hazard_pkg::*;
(
  input  logic [HZ_AW-1:0] addr,
  input  logic             use_e,
  input  stage_rec_t       rec_e,
  input  stage_rec_t       rec_m,
  input  stage_rec_t       rec_w,
  output logic             hit,
  output logic [1:0]       stage,
  output logic [HZ_TW-1:0] tnew
);

  // Priority search E, M, W; $0 never matches, so older records are
  // shadowed by the first producer found
  always_comb begin
    hit   = 1'b0;
    stage = FWD_NONE;
    tnew  = '0;
    if (addr != '0) begin
      if (use_e && is_producer(rec_e) && (rec_e.a3 == addr)) begin
        hit   = 1'b1;
        stage = FWD_E;
        tnew  = rec_e.tnew;
      end else if (is_producer(rec_m) && (rec_m.a3 == addr)) begin
        hit   = 1'b1;
        stage = FWD_M;
        tnew  = rec_m.tnew;
      end else if (is_producer(rec_w) && (rec_w.a3 == addr)) begin
        hit   = 1'b1;
        stage = FWD_W;
        tnew  = rec_w.tnew;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: keeps one record per in-flight instruction in E, M
// and W, and from those records plus the D-stage decode fields produces
// the pipeline stall and the D- and E-stage forward selects. All outputs
// are combinational on the registered records and the current D inputs.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int AW = HZ_AW,
  parameter int TW = HZ_TW
) (
  input  logic             clk,
  input  logic             reset,
  hazard_scoreboard_if.slave sb
);

  e_rec_t     rec_e;
  stage_rec_t rec_m;
  stage_rec_t rec_w;

  logic          rs_d_hit, rt_d_hit, rs_e_hit, rt_e_hit;
  logic [1:0]    rs_d_stage, rt_d_stage, rs_e_stage, rt_e_stage;
  logic [TW-1:0] rs_d_tnew, rt_d_tnew, rs_e_tnew, rt_e_tnew;
  logic          stall_rs, stall_rt, stall_all;
  e_rec_t        e_next;

  // D-stage operands see all three stages
  hazard_match u_match_rs_d (
    .addr  (sb.rs_d),
    .use_e (1'b1),
    .rec_e (rec_e.rec),
    .rec_m (rec_m),
    .rec_w (rec_w),
    .hit   (rs_d_hit),
    .stage (rs_d_stage),
    .tnew  (rs_d_tnew)
  );

  hazard_match u_match_rt_d (
    .addr  (sb.rt_d),
    .use_e (1'b1),
    .rec_e (rec_e.rec),
    .rec_m (rec_m),
    .rec_w (rec_w),
    .hit   (rt_d_hit),
    .stage (rt_d_stage),
    .tnew  (rt_d_tnew)
  );

  // E-stage operands cannot forward from themselves, so E is masked
  hazard_match u_match_rs_e (
    .addr  (rec_e.rs),
    .use_e (1'b0),
    .rec_e (rec_e.rec),
    .rec_m (rec_m),
    .rec_w (rec_w),
    .hit   (rs_e_hit),
    .stage (rs_e_stage),
    .tnew  (rs_e_tnew)
  );

  hazard_match u_match_rt_e (
    .addr  (rec_e.rt),
    .use_e (1'b0),
    .rec_e (rec_e.rec),
    .rec_m (rec_m),
    .rec_w (rec_w),
    .hit   (rt_e_hit),
    .stage (rt_e_stage),
    .tnew  (rt_e_tnew)
  );

  // Stall when the youngest producer of a used operand is not ready by the
  // time that operand is consumed (unsigned compare at width TW)
  always_comb begin
    stall_rs  = sb.rs_use_d && rs_d_hit && (rs_d_tnew > sb.tuse_rs_d);
    stall_rt  = sb.rt_use_d && rt_d_hit && (rt_d_tnew > sb.tuse_rt_d);
    stall_all = stall_rs | stall_rt;
  end

  // Forward selects: only a ready (tnew=0) youngest producer is a source;
  // while stalling the D-stage selects are held at NONE
  always_comb begin
    sb.stall    = stall_all;
    sb.fwd_rs_d = FWD_NONE;
    sb.fwd_rt_d = FWD_NONE;
    sb.fwd_rs_e = FWD_NONE;
    sb.fwd_rt_e = FWD_NONE;
    if (!stall_all && rs_d_hit && (rs_d_tnew == '0)) sb.fwd_rs_d = rs_d_stage;
    if (!stall_all && rt_d_hit && (rt_d_tnew == '0)) sb.fwd_rt_d = rt_d_stage;
    if (rs_e_hit && (rs_e_tnew == '0))               sb.fwd_rs_e = rs_e_stage;
    if (rt_e_hit && (rt_e_tnew == '0))               sb.fwd_rt_e = rt_e_stage;
  end

  // Record entering E: the D instruction, or a bubble when it is held in D
  always_comb begin
    e_next          = E_BUBBLE;
    if (!stall_all) begin
      e_next.rec.a3   = sb.a3_d;
      e_next.rec.we   = sb.regwrite_d;
      e_next.rec.tnew = sb.tnew_d;
      e_next.rs       = sb.rs_d;
      e_next.rt       = sb.rt_d;
    end
  end

  // Pipeline advance; reset wipes every record, including a stalled producer
  always_ff @(posedge clk) begin
    if (reset) begin
      rec_e <= E_BUBBLE;
      rec_m <= REC_BUBBLE;
      rec_w <= REC_BUBBLE;
    end else begin
      rec_e <= e_next;
      rec_m <= rec_advance(rec_e.rec);
      rec_w <= rec_advance(rec_m);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a table of per-cycle D-stage inputs
// with hand-computed stall/forward values, followed by a hand-written
// reset-during-stall sequence.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  typedef struct {
    string      name;
    logic       rst;
    logic [4:0] rs;
    logic       rs_use;
    logic [1:0] tuse_rs;
    logic [4:0] rt;
    logic       rt_use;
    logic [1:0] tuse_rt;
    logic [4:0] a3;
    logic       we;
    logic [1:0] tnew;
    logic       stall;
    logic [1:0] f_rs_d;
    logic [1:0] f_rt_d;
    logic [1:0] f_rs_e;
    logic [1:0] f_rt_e;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.AW(5), .TW(2)) sb ();

  hazard_scoreboard #(.AW(5), .TW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb)
  );

  // ---------------- scoreboard state ----------------
  logic [8:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  vec_t vecs[$];

  function automatic vec_t mk(
    input string name, input logic rst,
    input logic [4:0] rs, input logic rs_use, input logic [1:0] tuse_rs,
    input logic [4:0] rt, input logic rt_use, input logic [1:0] tuse_rt,
    input logic [4:0] a3, input logic we, input logic [1:0] tnew,
    input logic stall, input logic [1:0] f_rs_d, input logic [1:0] f_rt_d,
    input logic [1:0] f_rs_e, input logic [1:0] f_rt_e);
    vec_t v;
    v.name = name;  v.rst = rst;
    v.rs = rs;  v.rs_use = rs_use;  v.tuse_rs = tuse_rs;
    v.rt = rt;  v.rt_use = rt_use;  v.tuse_rt = tuse_rt;
    v.a3 = a3;  v.we = we;  v.tnew = tnew;
    v.stall = stall;
    v.f_rs_d = f_rs_d;  v.f_rt_d = f_rt_d;
    v.f_rs_e = f_rs_e;  v.f_rt_e = f_rt_e;
    return v;
  endfunction

  // ---------------- driver ----------------
  // Drive one cycle of D-stage inputs at the falling edge, check outputs
  // just after, and let the next rising edge advance the records.
  task automatic apply(input vec_t v);
    logic [8:0] got;
    logic [8:0] exp;
    @(negedge clk);
    reset         = v.rst;
    sb.rs_d       = v.rs;
    sb.rs_use_d   = v.rs_use;
    sb.tuse_rs_d  = v.tuse_rs;
    sb.rt_d       = v.rt;
    sb.rt_use_d   = v.rt_use;
    sb.tuse_rt_d  = v.tuse_rt;
    sb.a3_d       = v.a3;
    sb.regwrite_d = v.we;
    sb.tnew_d     = v.tnew;
    exp_q.push_back({v.stall, v.f_rs_d, v.f_rt_d, v.f_rs_e, v.f_rt_e});
    #1;
    got = {sb.stall, sb.fwd_rs_d, sb.fwd_rt_d, sb.fwd_rs_e, sb.fwd_rt_e};
    exp = exp_q.pop_front();
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got stall=%0b fwd rs_d/rt_d/rs_e/rt_e=%0d/%0d/%0d/%0d, expected stall=%0b fwd=%0d/%0d/%0d/%0d",
               v.name, got[8], got[7:6], got[5:4], got[3:2], got[1:0],
               exp[8], exp[7:6], exp[5:4], exp[3:2], exp[1:0]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset         = 1'b1;
    sb.rs_d       = '0;  sb.rs_use_d = 1'b0;  sb.tuse_rs_d = '0;
    sb.rt_d       = '0;  sb.rt_use_d = 1'b0;  sb.tuse_rt_d = '0;
    sb.a3_d       = '0;  sb.regwrite_d = 1'b0; sb.tnew_d = '0;
    repeat (2) @(posedge clk);

    //               name           rst rs ru tr  rt tu tt  a3 we tn  st frsd frtd frse frte
    // Right after reset: any D inputs see no hazard
    vecs.push_back(mk("reset_state",  0, 1, 1, 0,  2, 1, 0,  0, 0, 0,  0, 0, 0, 0, 0));
    // 1: LW $1 then ADD $2,$1,$3 (tuse 1)
    vecs.push_back(mk("t1_lw",        0, 2, 1, 1,  0, 0, 0,  1, 1, 2,  0, 0, 0, 0, 0));
    vecs.push_back(mk("t1_add_stall", 0, 1, 1, 1,  3, 1, 1,  2, 1, 1,  1, 0, 0, 0, 0));
    vecs.push_back(mk("t1_add_go",    0, 1, 1, 1,  3, 1, 1,  2, 1, 1,  0, 0, 0, 0, 0));
    vecs.push_back(mk("t1_add_in_e",  0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 3, 0));
    vecs.push_back(mk("t1_drain",     0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0));
    // 2: LW $1 then BEQ $1,$0 (tuse 0): two stall cycles, then W forward
    vecs.push_back(mk("t2_lw",        0, 0, 0, 0,  0, 0, 0,  1, 1, 2,  0, 0, 0, 0, 0));
    vecs.push_back(mk("t2_beq_st1",   0, 1, 1, 0,  0, 1, 0,  0, 0, 0,  1, 0, 0, 0, 0));
    vecs.push_back(mk("t2_beq_st2",   0, 1, 1, 0,  0, 1, 0,  0, 0, 0,  1, 0, 0, 0, 0));
    vecs.push_back(mk("t2_beq_go",    0, 1, 1, 0,  0, 1, 0,  0, 0, 0,  0, 3, 0, 0, 0));
    // 3: ORI $4 (tnew 1) then BEQ $4,$4 (tuse 0): one stall, then M forward
    vecs.push_back(mk("t3_ori",       0, 0, 1, 1,  0, 0, 0,  4, 1, 1,  0, 0, 0, 0, 0));
    vecs.push_back(mk("t3_beq_stall", 0, 4, 1, 0,  4, 1, 0,  0, 0, 0,  1, 0, 0, 0, 0));
    vecs.push_back(mk("t3_beq_go",    0, 4, 1, 0,  4, 1, 0,  0, 0, 0,  0, 2, 2, 0, 0));
    // 4: JAL $31 then JR $31; BEQ $4,$4 now in E sees ORI in W
    vecs.push_back(mk("t4_jal",       0, 0, 0, 0,  0, 0, 0, 31, 1, 0,  0, 0, 0, 3, 3));
    vecs.push_back(mk("t4_jr",        0,31, 1, 0,  0, 0, 0,  0, 0, 0,  0, 1, 0, 0, 0));
    // Shadowing: ORI $5, ADD $5 ($6,$7), SUB reads $5 -> youngest is ADD in E
    vecs.push_back(mk("t4_ori5",      0, 0, 1, 1,  0, 0, 0,  5, 1, 1,  0, 0, 0, 2, 0));
    vecs.push_back(mk("t4_add5",      0, 6, 1, 1,  7, 1, 1,  5, 1, 1,  0, 0, 0, 0, 0));
    vecs.push_back(mk("t4_sub_shadow",0, 5, 1, 1,  0, 1, 1,  8, 1, 1,  0, 0, 0, 0, 0));
    vecs.push_back(mk("t4_sub_in_e",  0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 2, 0));
    // 5: writes to $0 never hazard; regwrite=0 records are ignored
    vecs.push_back(mk("t5_w0_a",      0, 0, 0, 0,  0, 0, 0,  0, 1, 2,  0, 0, 0, 0, 0));
    vecs.push_back(mk("t5_w0_rd0",    0, 0, 1, 0,  0, 1, 0,  0, 1, 2,  0, 0, 0, 0, 0));
    vecs.push_back(mk("t5_rd0_nowe9", 0, 0, 1, 0,  0, 1, 0,  9, 0, 2,  0, 0, 0, 0, 0));
    vecs.push_back(mk("t5_rd9_e_nowe",0, 9, 1, 0,  9, 1, 0,  0, 0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk("t5_rd9_m_nowe",0, 9, 1, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // 6: LW $1, dependent BEQ, reset lands in the first stall cycle
    apply(mk("t6_lw",           0, 0, 0, 0,  0, 0, 0,  1, 1, 2,  0, 0, 0, 0, 0));
    apply(mk("t6_beq_stall_rst",1, 1, 1, 0,  0, 1, 0,  0, 0, 0,  1, 0, 0, 0, 0));
    apply(mk("t6_beq_after_rst",0, 1, 1, 0,  0, 1, 0,  0, 0, 0,  0, 0, 0, 0, 0));
    apply(mk("t6_beq_in_e",     0, 1, 1, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0));

    // ---------------- report ----------------
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
